// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter slice.
package rf_write_arbiter_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_ZERO_REG = 0;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requester, register-file write/read port and forwarding signals.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] Addr3;
    logic [DATA_W-1:0] WD3;
    logic [ADDR_W-1:0] Addr1;
    logic [ADDR_W-1:0] Addr2;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  Addr1, Addr2,
        output req0_ready, req1_ready,
        output RegWrite, Addr3, WD3,
        output fwd1_hit, fwd2_hit, fwd_data, conflict_cnt
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output Addr1, Addr2,
        input  req0_ready, req1_ready,
        input  RegWrite, Addr3, WD3,
        input  fwd1_hit, fwd2_hit, fwd_data, conflict_cnt
    );
endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer flips away from the last winner.
module rr_arb2
    import rf_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic       grant_vld,
    output logic       grant_idx
);

    logic prio_q;

    always_comb begin
        grant_vld = |valid;
        grant_idx = REQ_ALU;
        if (valid[0] && valid[1])
            grant_idx = prio_q;
        else if (valid[1])
            grant_idx = REQ_MEM;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            prio_q <= REQ_ALU;
        else if (grant_vld)
            prio_q <= ~grant_idx;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, registers
// the winner for one cycle and forwards the in-flight write to the read ports.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_write_arbiter_if.slave    bus
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              grant_vld;
    logic              grant_idx;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic              regwrite_q;
    logic [ADDR_W-1:0] addr3_q;
    logic [DATA_W-1:0] wd3_q;
    logic [CNT_W-1:0]  cnt_q;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     ({bus.req1_valid, bus.req0_valid}),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    // Readies are masked during reset so nothing is accepted while held.
    assign xfer           = rst && grant_vld;
    assign bus.req0_ready = xfer && (grant_idx == REQ_ALU);
    assign bus.req1_ready = xfer && (grant_idx == REQ_MEM);

    assign win_addr = (grant_idx == REQ_MEM) ? bus.req1_addr : bus.req0_addr;
    assign win_data = (grant_idx == REQ_MEM) ? bus.req1_data : bus.req0_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            addr3_q    <= '0;
            wd3_q      <= '0;
            cnt_q      <= '0;
        end else begin
            if (xfer) begin
                regwrite_q <= (win_addr != ZERO_ADDR);
                addr3_q    <= win_addr;
                wd3_q      <= win_data;
            end else begin
                regwrite_q <= 1'b0;
            end
            if (bus.req0_valid && bus.req1_valid && (cnt_q != CNT_MAX))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.RegWrite     = regwrite_q;
    assign bus.Addr3        = addr3_q;
    assign bus.WD3          = wd3_q;
    assign bus.fwd_data     = wd3_q;
    assign bus.conflict_cnt = cnt_q;

    // The write commits at the next edge, so same-cycle reads must take it from here.
    assign bus.fwd1_hit = regwrite_q && (addr3_q == bus.Addr1) && (bus.Addr1 != ZERO_ADDR);
    assign bus.fwd2_hit = regwrite_q && (addr3_q == bus.Addr2) && (bus.Addr2 != ZERO_ADDR);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed vector table plus hand sequences for reset, saturation and mid-stream reset.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 3;

    typedef struct {
        bit          v0;
        bit [AW-1:0] a0;
        bit [DW-1:0] d0;
        bit          v1;
        bit [AW-1:0] a1;
        bit [DW-1:0] d1;
        bit [AW-1:0] ra1;
        bit [AW-1:0] ra2;
        bit          e_r0;
        bit          e_r1;
        bit          e_we;
        bit [AW-1:0] e_a3;
        bit [DW-1:0] e_wd3;
        bit          e_f1;
        bit          e_f2;
        bit [CW-1:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[11];

    rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit v0, bit [AW-1:0] a0, bit [DW-1:0] d0,
                                bit v1, bit [AW-1:0] a1, bit [DW-1:0] d1,
                                bit [AW-1:0] ra1, bit [AW-1:0] ra2,
                                bit e_r0, bit e_r1, bit e_we, bit [AW-1:0] e_a3,
                                bit [DW-1:0] e_wd3, bit e_f1, bit e_f2, bit [CW-1:0] e_cnt);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.ra1 = ra1; v.ra2 = ra2;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_we = e_we; v.e_a3 = e_a3;
        v.e_wd3 = e_wd3; v.e_f1 = e_f1; v.e_f2 = e_f2; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v0, input bit [AW-1:0] a0, input bit [DW-1:0] d0,
                         input bit v1, input bit [AW-1:0] a1, input bit [DW-1:0] d1,
                         input bit [AW-1:0] ra1, input bit [AW-1:0] ra2);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        bus.Addr1 = ra1; bus.Addr2 = ra2;
    endtask

    initial begin
        bit           exp_g;
        bit [CW-1:0]  exp_cnt;
        bit [AW-1:0]  prev_a;

        //          v0 a0  d0           v1 a1  d1            ra1 ra2 r0 r1 we a3  wd3           f1 f2 cnt
        tbl[0]  = mk(1, 1, 32'h11,       1, 9,  32'h99,       0,  0,  1, 0, 0, 0,  32'h0,        0, 0, 0);
        tbl[1]  = mk(1, 2, 32'h22,       1, 9,  32'h99,       1,  0,  0, 1, 1, 1,  32'h11,       1, 0, 1);
        tbl[2]  = mk(1, 2, 32'h22,       1, 10, 32'hA0,       0,  9,  1, 0, 1, 9,  32'h99,       0, 1, 2);
        tbl[3]  = mk(1, 3, 32'h33,       1, 10, 32'hA0,       2,  2,  0, 1, 1, 2,  32'h22,       1, 1, 3);
        tbl[4]  = mk(0, 3, 32'h33,       1, 5,  32'hDEADBEEF, 0,  0,  0, 1, 1, 10, 32'hA0,       0, 0, 4);
        tbl[5]  = mk(1, 0, 32'h55,       0, 5,  32'h0,        5,  0,  1, 0, 1, 5,  32'hDEADBEEF, 1, 0, 4);
        tbl[6]  = mk(1, 3, 32'h33,       1, 12, 32'hC0,       0,  0,  0, 1, 0, 0,  32'h55,       0, 0, 4);
        tbl[7]  = mk(1, 7, 32'h1234,     0, 0,  32'h0,        12, 3,  1, 0, 1, 12, 32'hC0,       1, 0, 5);
        tbl[8]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        7,  0,  0, 0, 1, 7,  32'h1234,     1, 0, 5);
        tbl[9]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        7,  0,  0, 0, 0, 7,  32'h1234,     0, 0, 5);
        tbl[10] = mk(0, 0, 32'h0,        0, 0,  32'h0,        7,  7,  0, 0, 0, 7,  32'h1234,     0, 0, 5);

        rst = 1'b0;
        drive(1, 1, 32'h11, 1, 9, 32'h99, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("rst_ready0", bus.req0_ready, 0);
            chk("rst_ready1", bus.req1_ready, 0);
            chk("rst_regwrite", bus.RegWrite, 0);
            chk("rst_cnt", bus.conflict_cnt, 0);
        end
        chk("rst_addr3", bus.Addr3, 0);
        chk("rst_wd3", bus.WD3, 0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
                  tbl[i].ra1, tbl[i].ra2);
            #1;
            chk($sformatf("v%0d_ready0", i), bus.req0_ready, tbl[i].e_r0);
            chk($sformatf("v%0d_ready1", i), bus.req1_ready, tbl[i].e_r1);
            chk($sformatf("v%0d_regwrite", i), bus.RegWrite, tbl[i].e_we);
            chk($sformatf("v%0d_addr3", i), bus.Addr3, tbl[i].e_a3);
            chk($sformatf("v%0d_wd3", i), bus.WD3, tbl[i].e_wd3);
            chk($sformatf("v%0d_fwd_data", i), bus.fwd_data, tbl[i].e_wd3);
            chk($sformatf("v%0d_fwd1", i), bus.fwd1_hit, tbl[i].e_f1);
            chk($sformatf("v%0d_fwd2", i), bus.fwd2_hit, tbl[i].e_f2);
            chk($sformatf("v%0d_cnt", i), bus.conflict_cnt, tbl[i].e_cnt);
            @(posedge clk); #1;
        end

        // Sustained contention from count 5; last transfer left the pointer on requester 1.
        exp_g   = 1'b1;
        exp_cnt = 3'd5;
        prev_a  = '0;
        for (int i = 0; i < 10; i++) begin
            drive(1, AW'(i + 1), DW'(32'h100 + i), 1, AW'(i + 16), DW'(32'h200 + i), 0, 0);
            #1;
            chk($sformatf("sat%0d_ready0", i), bus.req0_ready, !exp_g);
            chk($sformatf("sat%0d_ready1", i), bus.req1_ready, exp_g);
            chk($sformatf("sat%0d_cnt", i), bus.conflict_cnt, exp_cnt);
            if (i > 0) begin
                chk($sformatf("sat%0d_regwrite", i), bus.RegWrite, 1);
                chk($sformatf("sat%0d_addr3", i), bus.Addr3, prev_a);
            end
            prev_a  = exp_g ? AW'(i + 16) : AW'(i + 1);
            exp_g   = !exp_g;
            if (exp_cnt != 3'd7) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
        chk("sat_final_cnt", bus.conflict_cnt, 7);
        chk("sat_final_regwrite", bus.RegWrite, 1);

        rst = 1'b0;
        #1;
        chk("midrst_ready0", bus.req0_ready, 0);
        chk("midrst_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        chk("midrst_regwrite", bus.RegWrite, 0);
        chk("midrst_cnt", bus.conflict_cnt, 0);
        chk("midrst_addr3", bus.Addr3, 0);
        chk("midrst_wd3", bus.WD3, 0);
        rst = 1'b1;
        drive(1, 4, 32'h44, 1, 20, 32'h2020, 0, 0);
        #1;
        chk("post_rst_ready0", bus.req0_ready, 1);
        chk("post_rst_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        chk("post_rst_regwrite", bus.RegWrite, 1);
        chk("post_rst_addr3", bus.Addr3, 4);
        chk("post_rst_cnt", bus.conflict_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
